// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises N_CH sources, latches pending requests,
// masks them and presents the highest-priority one to the CPU with an ack/eoi handshake.
module int_ctrl #(
  parameter int unsigned       N_CH      = 8,
  parameter logic [N_CH-1:0]   EDGE_MODE = '1,
  parameter logic [31:0]       VEC_BASE  = 32'h10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] irq,
  input  logic            mask_we,
  input  logic [N_CH-1:0] mask_wdata,
  input  logic [N_CH-1:0] pend_clr,
  input  logic            int_ack,
  input  logic            eoi,
  output logic            INTin,
  output logic [31:0]     INTnum,
  output logic [N_CH-1:0] mask,
  output logic [N_CH-1:0] pending,
  output logic            in_service
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SVC
  } state_e;

  state_e          state_q, state_d;
  logic [N_CH-1:0] s1_q, s2_q, s3_q;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic            intin_q, intin_d;
  logic [31:0]     intnum_q, intnum_d;
  logic            insvc_q, insvc_d;

  logic [N_CH-1:0] req;
  logic [CW-1:0]   grant;
  logic            grant_vld;
  logic            ack_clr;
  logic [N_CH-1:0] ack_vec;
  logic [N_CH-1:0] clr_vec;
  logic [N_CH-1:0] edge_set;

  assign req = pending_q & ~mask_q;

  // Lowest set index wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (req[i] && !grant_vld) begin
        grant     = CW'(i);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    intin_d  = intin_q;
    intnum_d = intnum_q;
    insvc_d  = insvc_q;
    ack_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          cur_ch_d = grant;
          intin_d  = 1'b1;
          intnum_d = VEC_BASE + 32'(grant);
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          intin_d = 1'b0;
          insvc_d = 1'b1;
          ack_clr = 1'b1;
          state_d = S_SVC;
        end else if (!req[cur_ch_q]) begin
          intin_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SVC: begin
        if (eoi) begin
          insvc_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        intin_d = 1'b0;
        insvc_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Edge channels: a new edge beats a same-cycle clear. Level channels follow s2.
  always_comb begin
    ack_vec = '0;
    if (ack_clr) ack_vec[cur_ch_q] = 1'b1;
    clr_vec   = pend_clr | ack_vec;
    edge_set  = s2_q & ~s3_q;
    pending_d = (EDGE_MODE & (edge_set | (pending_q & ~clr_vec))) | (~EDGE_MODE & s2_q);
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      cur_ch_q  <= '0;
      intin_q   <= 1'b0;
      intnum_q  <= '0;
      insvc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= irq;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cur_ch_q  <= cur_ch_d;
      intin_q   <= intin_d;
      intnum_q  <= intnum_d;
      insvc_q   <= insvc_d;
    end
  end

  assign INTin      = intin_q;
  assign INTnum     = intnum_q;
  assign mask       = mask_q;
  assign pending    = pending_q;
  assign in_service = insvc_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: a directed vector table, handshake corner-case sequences,
// and randomized traffic checked every cycle against a behavioural model.
module tb_int_ctrl;
  localparam int          N  = 8;
  localparam logic [N-1:0] EM = 8'hFE;
  localparam logic [31:0] VB = 32'h10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [N-1:0] pend_clr;
  logic         int_ack;
  logic         eoi;
  logic         INTin;
  logic [31:0]  INTnum;
  logic [N-1:0] mask;
  logic [N-1:0] pending;
  logic         in_service;

  always #5 clk = ~clk;

  int_ctrl #(.N_CH(N), .EDGE_MODE(EM), .VEC_BASE(VB)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pend_clr(pend_clr), .int_ack(int_ack), .eoi(eoi), .INTin(INTin), .INTnum(INTnum),
    .mask(mask), .pending(pending), .in_service(in_service)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: last three irq samples, pending/mask vectors, handshake flags.
  logic [N-1:0] m_h1, m_h2, m_h3, m_pend, m_mask;
  bit           m_pres, m_svc;
  int           m_ch;
  logic [31:0]  m_num;

  task automatic model_edge();
    logic [N-1:0] rq, setv, clrv;
    if (!rst) begin
      m_h1 = '0; m_h2 = '0; m_h3 = '0; m_pend = '0; m_mask = '1;
      m_pres = 0; m_svc = 0; m_ch = 0; m_num = '0;
      return;
    end
    rq   = m_pend & ~m_mask;
    clrv = pend_clr;
    if (m_svc) begin
      if (eoi) m_svc = 0;
    end else if (m_pres) begin
      if (int_ack) begin
        m_pres = 0; m_svc = 1; clrv[m_ch] = 1'b1;
      end else if (!rq[m_ch]) begin
        m_pres = 0;
      end
    end else if (rq != '0) begin
      for (int c = N - 1; c >= 0; c--) if (rq[c]) m_ch = c;
      m_pres = 1;
      m_num  = VB + 32'(m_ch);
    end
    setv   = m_h2 & ~m_h3;
    m_pend = (EM & (setv | (m_pend & ~clrv))) | (~EM & m_h2);
    if (mask_we) m_mask = mask_wdata;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("INTin", 32'(INTin), 32'(m_pres));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("mask", 32'(mask), 32'(m_mask));
    chk("in_service", 32'(in_service), 32'(m_svc));
    if (m_pres) chk("INTnum", INTnum, m_num);
    int_ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; pend_clr = '0;
  endtask

  task automatic wait_int(input string name);
    int n = 0;
    while (INTin !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({name, "_wait"}, 32'(INTin === 1'b1), 32'd1);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] irq;
    logic         mwe;
    logic [N-1:0] mwd;
    logic         ack;
    logic         eoi;
    logic         e_int;
    logic [31:0]  e_num;
    logic         chk_num;
    logic [N-1:0] e_pend;
    logic         e_svc;
    logic [N-1:0] e_mask;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0; pend_clr = '0;
    int_ack = 1'b0; eoi = 1'b0;

    // Edge request on channel 3: reset, unmask, 2-cycle pulse, ack, eoi.
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 8'h00, 1'b0, 8'hFF};
    tbl[1]  = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h08, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 8'h08, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 8'h08, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 1'b1, 8'h00};
    tbl[9]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 8'h00, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 8'h00, 1'b0, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; irq = tbl[i].irq; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mwd;
      int_ack = tbl[i].ack; eoi = tbl[i].eoi;
      step();
      chk($sformatf("tbl%0d_INTin", i), 32'(INTin), 32'(tbl[i].e_int));
      chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_in_service", i), 32'(in_service), 32'(tbl[i].e_svc));
      chk($sformatf("tbl%0d_mask", i), 32'(mask), 32'(tbl[i].e_mask));
      if (tbl[i].chk_num) chk($sformatf("tbl%0d_INTnum", i), INTnum, tbl[i].e_num);
    end

    // Priority: channels 2 and 5 together.
    irq = 8'h24; step(); step(); irq = '0;
    wait_int("prio1");
    chk("prio_first", INTnum, 32'h12);
    int_ack = 1'b1; step();
    eoi = 1'b1; step();
    wait_int("prio2");
    chk("prio_second", INTnum, 32'h15);
    int_ack = 1'b1; step();
    eoi = 1'b1; step();

    // Mask-induced withdraw on channel 1, then re-issue.
    irq = 8'h02; step(); step(); irq = '0;
    wait_int("wd");
    chk("wd_num", INTnum, 32'h11);
    mask_we = 1'b1; mask_wdata = 8'h02; step();
    chk("wd_still", 32'(INTin), 32'd1);
    step();
    chk("wd_drop", 32'(INTin), 32'd0);
    chk("wd_pend", 32'(pending[1]), 32'd1);
    chk("wd_svc", 32'(in_service), 32'd0);
    mask_we = 1'b1; mask_wdata = 8'h00; step();
    wait_int("wd_re");
    chk("wd_re_num", INTnum, 32'h11);
    chk("wd_re_pend", 32'(pending[1]), 32'd1);
    int_ack = 1'b1; step();
    eoi = 1'b1; step();

    // Level channel 0 held through ack/eoi, then dropped during REQ.
    irq = 8'h01;
    wait_int("lvl1");
    chk("lvl_num", INTnum, 32'h10);
    int_ack = 1'b1; step();
    chk("lvl_pend", 32'(pending[0]), 32'd1);
    step();
    eoi = 1'b1; step();
    chk("lvl_eoi_idle", 32'(INTin), 32'd0);
    step();
    chk("lvl_again", 32'(INTin), 32'd1);
    chk("lvl_again_num", INTnum, 32'h10);
    irq = '0;
    for (int n = 0; n < 10 && INTin === 1'b1; n++) step();
    chk("lvl_withdraw", 32'(INTin), 32'd0);
    chk("lvl_withdraw_svc", 32'(in_service), 32'd0);

    // New edge on channel 4 lands on the same edge as its ack.
    irq = 8'h10; step(); step(); irq = '0;
    wait_int("col1");
    chk("col_num", INTnum, 32'h14);
    irq = 8'h10; step(); step();
    irq = '0; int_ack = 1'b1; step();
    chk("col_pend", 32'(pending[4]), 32'd1);
    chk("col_svc", 32'(in_service), 32'd1);
    eoi = 1'b1; step();
    step();
    chk("col_again", 32'(INTin), 32'd1);
    chk("col_again_num", INTnum, 32'h14);
    int_ack = 1'b1; step();
    eoi = 1'b1; step();

    // Reset while in service.
    irq = 8'h04; step(); step(); irq = '0;
    wait_int("rs1");
    int_ack = 1'b1; step();
    chk("rs_svc", 32'(in_service), 32'd1);
    rst = 1'b0; step(); rst = 1'b1;
    chk("rs_INTin", 32'(INTin), 32'd0);
    chk("rs_INTnum", INTnum, 32'h0);
    chk("rs_in_service", 32'(in_service), 32'd0);
    chk("rs_pending", 32'(pending), 32'd0);
    chk("rs_mask", 32'(mask), 32'hFF);
    irq = 8'h40;
    for (int n = 0; n < 6; n++) step();
    chk("rs_masked", 32'(INTin), 32'd0);
    chk("rs_pend6", 32'(pending[6]), 32'd1);
    mask_we = 1'b1; mask_wdata = 8'h00; step();
    wait_int("rs_unmask");
    chk("rs_unmask_num", INTnum, 32'h16);
    irq = '0;
    int_ack = 1'b1; step();
    eoi = 1'b1; step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq = irq ^ (8'(1) << $urandom_range(0, 7));
      int_ack = (INTin && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
      eoi = (in_service && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) begin
        mask_we = 1'b1;
        mask_wdata = 8'($urandom) & 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) pend_clr = 8'(1) << $urandom_range(0, 7);
      rst = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised interrupt controller that feeds the CPU's single `INTin`/`INTnum` pair from `N_CH` independent interrupt sources. It synchronises the sources, latches pending requests (per-channel edge or level mode), applies a software mask, and selects the highest-priority unmasked request. It then runs a request/acknowledge/end-of-interrupt handshake with the CPU so that exactly one interrupt is in service at a time. It sits between the peripherals (UART, timer, DMA) and the CPU interrupt inputs.

## Interface
- `N_CH`, 8, number of interrupt channels (1..32); channel 0 has the highest priority.
- `EDGE_MODE`, `{N_CH{1'b1}}`, per-channel mode bit: 1 = rising-edge latched, 0 = level.
- `VEC_BASE`, 32'h10, cause code base; `INTnum` = `VEC_BASE` + channel index.
- `clk`  in  1  CPU clock; all logic is on its rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `irq`  in  N_CH  raw interrupt sources, asynchronous to `clk`.
- `mask_we`  in  1  load `mask` from `mask_wdata`.
- `mask_wdata`  in  N_CH  new mask value; 1 = channel masked.
- `pend_clr`  in  N_CH  one-cycle clear strobes for edge-mode pending bits.
- `int_ack`  in  1  one-cycle pulse: the CPU has taken the interrupt (cause latched).
- `eoi`  in  1  one-cycle pulse: the CPU has executed `eret`.
- `INTin`  out  1  interrupt request to the CPU.
- `INTnum`  out  32  cause code; valid while `INTin`=1.
- `mask`  out  N_CH  current mask register.
- `pending`  out  N_CH  current pending vector, before masking.
- `in_service`  out  1  high from `int_ack` until `eoi`.

## Operation
- Each `irq` bit passes through a 2-flop synchroniser (`s1`, `s2`) plus a history flop `s3` for edge detection.
- Edge channel: `pending[i]` is set when `s2 & ~s3`. It is cleared by `int_ack` when `i` is the granted channel, or by `pend_clr[i]`. If a set and a clear occur in the same cycle, the set wins.
- Level channel: `pending[i] = s2[i]`. `pend_clr` and ack have no effect on it.
- `mask_we` has priority over nothing else; the write takes effect on the next edge.
- Eligible requests: `req = pending & ~mask`. The grant goes to the lowest set index.
- State machine, 3 states:
  - IDLE: if `req != 0`, latch `cur_ch`, set `INTin`=1 and `INTnum`=`VEC_BASE`+`cur_ch`, and go to REQ.
  - REQ: hold `INTin` and `INTnum` stable, with no re-arbitration. On `int_ack`: `INTin`=0, clear `pending[cur_ch]` (edge channels), `in_service`=1, go to SVC. If `req[cur_ch]` drops without an ack (masked, level source deasserted, or `pend_clr`): withdraw, with `INTin`=0 and back to IDLE.
  - SVC: ignore new requests; they remain pending. On `eoi`: `in_service`=0 and go to IDLE.
- `int_ack` outside REQ and `eoi` outside SVC are ignored.
- A simultaneous `int_ack` and withdraw condition in REQ is treated as an ack.
- `INTnum[31:0]` = `VEC_BASE` + `cur_ch`, with the channel index zero-extended and the sum modulo 2^32.

## Timing
- Reset (`rst`=0 at a clock edge) sets:
  - `INTin`=0, `INTnum`=0, `in_service`=0
  - `pending`=0, synchroniser flops=0
  - `mask`=all ones, state=IDLE
- Reset mid-handshake abandons the interrupt without any ack or eoi.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: an `irq` rise sampled at edge k gives `s2` at edge k+1 and `pending` at edge k+2. With the channel unmasked and the controller idle, `INTin`=1 after edge k+3.
- After `eoi` at edge e: state is IDLE after edge e. The next `INTin` asserts after edge e+1 if a request is eligible.
- After a withdraw at edge w: re-arbitration happens at edge w+1.
- `irq` pulses must be at least 2 `clk` cycles wide to be guaranteed capture.
- Repeated edges on one channel before its ack collapse into a single pending bit.

## Test plan
- Edge request: with `mask`=0, raise `irq[3]` for 2 cycles → `INTin`=1 three cycles after sampling, `INTnum`=32'h13; `int_ack` → `INTin`=0, `pending[3]`=0, `in_service`=1; `eoi` → `in_service`=0.
- Priority: raise `irq[5]` and `irq[2]` together → `INTnum`=32'h12 first; after ack and eoi, `INTnum`=32'h15 is presented.
- Masking and withdraw: request on channel 1 in REQ, then `mask_we` with `mask_wdata`=8'h02 → `INTin` drops the next cycle with no ack; clear the mask → request re-issued, `pending[1]` still 1.
- Level channel (`EDGE_MODE[0]`=0): hold `irq[0]` high through ack and eoi → second request with `INTnum`=32'h10 one cycle after eoi; drop `irq[0]` during REQ → withdraw.
- Set/clear collision: a new edge on channel 4 in the same cycle as the `int_ack` of channel 4 → `pending[4]`=1 afterwards; after eoi, channel 4 is requested again.
- Reset mid-SVC: assert `rst`=0 for one cycle → all outputs at reset values, `mask`=8'hFF, and no `INTin` until the mask is cleared.
